// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RISC-V core front end.
`default_nettype none

package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_t;
endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load/flush/hold control.
// Carries a misalign flag only when IF_MISALIGN_TRAP_EN is defined.
`default_nettype none

module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_VALUE = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
`ifdef IF_MISALIGN_TRAP_EN
  input  logic            load_misalign,
  output logic            misalign,
`endif
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  output logic            valid
);

  // Flush wins over load so a redirect never lets a stale word through.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= NOP_VALUE;
      pc      <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= NOP_VALUE;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= load_instr;
      pc      <= load_pc;
      pcplus4 <= load_pc + XLEN'(4);
      valid   <= 1'b1;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      misalign <= 1'b0;
    end else if (load) begin
      misalign <= load_misalign;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: PC, one-outstanding instruction fetch and IF/ID register.
// Optional IF_MISALIGN_TRAP_EN keeps misaligned redirect targets and flags them.
`default_nettype none

module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stalld,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcplus4d,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        misalignd,
`endif
  output logic        validd
);

  if_state_t   state, state_next;
  logic [31:0] pc, pc_next;
  logic        kill, kill_next;
  logic [31:0] hold_instr, hold_next;
  logic        load, flush;
  logic [31:0] load_instr;
  logic [31:0] target;

`ifdef IF_MISALIGN_TRAP_EN
  assign target = pctarget;
`else
  assign target = pctarget & 32'hFFFF_FFFC;
`endif

  assign imem_req  = (state == IF_REQ) && !reset;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IF_REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      kill       <= kill_next;
      hold_instr <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    hold_next  = hold_instr;
    load       = 1'b0;
    flush      = 1'b0;
    load_instr = imem_rdata;

    case (state)
      IF_REQ: state_next = IF_WAIT;
      IF_WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            kill_next  = 1'b0;
            state_next = IF_REQ;
          end else if (!validd || !stalld) begin
            load       = 1'b1;
            pc_next    = pc + 32'd4;
            state_next = IF_REQ;
          end else begin
            hold_next  = imem_rdata;
            state_next = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (!stalld) begin
          load       = 1'b1;
          load_instr = hold_instr;
          pc_next    = pc + 32'd4;
          state_next = IF_REQ;
        end
      end
      default: state_next = IF_REQ;
    endcase

    // Redirect overrides everything; a fetch in flight must be discarded.
    if (pcsrc) begin
      load    = 1'b0;
      flush   = 1'b1;
      pc_next = target;
      case (state)
        IF_REQ: begin
          kill_next  = 1'b1;
          state_next = IF_WAIT;
        end
        IF_WAIT: begin
          kill_next  = !imem_rvalid;
          state_next = imem_rvalid ? IF_REQ : IF_WAIT;
        end
        default: begin
          kill_next  = 1'b0;
          state_next = IF_REQ;
        end
      endcase
    end else if (!stalld && !load) begin
      flush = 1'b1;
    end
  end

  ifid_reg #(
    .NOP_VALUE     (NOP_INSTR)
  ) u_ifid (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .flush         (flush),
    .load_instr    (load_instr),
    .load_pc       (pc),
`ifdef IF_MISALIGN_TRAP_EN
    .load_misalign (pc[1:0] != 2'b00),
    .misalign      (misalignd),
`endif
    .instr         (instrd),
    .pc            (pcd),
    .pcplus4       (pcplus4d),
    .valid         (validd)
  );

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction fetch stage for the RISC-V core. It holds the program counter and issues word fetches to instruction memory with a one-outstanding-request handshake. It registers each returned instruction into the IF/ID pipeline register that feeds the decoder and the immediate extender (`instrd[31:7]`). It also handles decode-stage stalls and branch/jump redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0013: value `instrd` holds when invalid (`addi x0,x0,0`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stalld` input 1: decode cannot accept; IF/ID holds its contents.
- `pcsrc` input 1: redirect request from execute.
- `pctarget` input 32: redirect address.
- `imem_req` output 1: fetch request, one-cycle pulse.
- `imem_addr` output 32: fetch address, equal to `pc`.
- `imem_rvalid` input 1: read data valid. Earliest arrival is 1 cycle after `imem_req`; latency is unbounded.
- `imem_rdata` input 32: instruction word.
- `instrd` output 32: IF/ID instruction.
- `pcd` output 32: IF/ID PC.
- `pcplus4d` output 32: `pcd + 4`.
- `validd` output 1: IF/ID holds a live instruction.
- `misalignd` output 1: present only with `IF_MISALIGN_TRAP_EN` (see Configuration).

## Operation
- FSM states: REQ, WAIT, HOLD.
- REQ: drive `imem_req=1`, `imem_addr=pc`; move to WAIT unconditionally.
- WAIT, `imem_rvalid=1`, kill flag clear:
  - If `validd=0` or `stalld=0`: load IF/ID with `imem_rdata`, `pc`, `pc+4`; set `validd=1`; update `pc<=pc+4`; go to REQ.
  - Otherwise: capture the data into a hold register; go to HOLD.
- WAIT, `imem_rvalid=1`, kill flag set: drop the data, clear kill, go to REQ.
- HOLD: when `stalld=0`, move the hold register into IF/ID, update `pc<=pc+4`, go to REQ.
- IF/ID consumed with nothing to load (`stalld=0`, no load this cycle): `validd<=0`, `instrd<=NOP_INSTR`.
- Redirect (`pcsrc=1`) takes priority over stall and over every other action:
  - `pc<=pctarget`; IF/ID flushed (`validd=0`, `instrd=NOP_INSTR`).
  - From REQ: the request issued this cycle is killed.
  - From WAIT: kill flag set. If `imem_rvalid` arrives in the same cycle, that data is dropped and the FSM goes to REQ.
  - From HOLD: the hold register is discarded; go to REQ.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `pc=RESET_PC`, state=REQ, `imem_req=0` during the reset cycle, `validd=0`, `instrd=NOP_INSTR`, `pcd=0`, `pcplus4d=0`, kill=0, `misalignd=0`.
- First `imem_req` is in the first cycle after `reset` deasserts.
- `imem_rvalid` at cycle t gives `validd=1` at t+1. Next `imem_req` is at t+1.
- Best-case throughput: 1 instruction per 2 cycles with 1-cycle memory.
- Reset mid-fetch: state returns to REQ and kill is cleared. An `imem_rvalid` arriving after reset is ignored unless the FSM is in WAIT.
- `imem_rvalid` outside WAIT is ignored.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - On redirect with `pctarget[1:0]!=0`, the target is loaded unmodified.
  - The fetch still issues; its result is loaded with `misalignd=1`, so the trap is raised downstream.
- Not defined:
  - `pctarget[1:0]` is forced to 2'b00.
  - No `misalignd` port.

## Structure
- Shared package `riscv_pkg`: FSM state enum (`IF_REQ`, `IF_WAIT`, `IF_HOLD`), `NOP_INSTR`, `XLEN=32`.
- One sub-module `ifid_reg`: the IF/ID register (load, flush, hold controls) carrying instr, pc, pcplus4, valid.

## Test plan
- Reset, then 1-cycle memory returning 0x00500093 at address 0 → `imem_req` pulses at PC 0, 4, 8. `instrd=0x00500093`, `pcd=0`, `pcplus4d=4`, `validd=1` one cycle after `imem_rvalid`.
- `stalld=1` held 3 cycles while a response arrives → FSM enters HOLD. IF/ID is unchanged. After stall release the held word appears next cycle and `pc` advances by exactly 4.
- `pcsrc=1`, `pctarget=0x100` while in WAIT, response arrives 2 cycles later → response dropped, `validd=0`, next `imem_addr=0x100`.
- Redirect and `imem_rvalid` in the same cycle → data dropped, `pc=pctarget`, no `validd` pulse.
- PC at 0xFFFF_FFFC, fetch completes → next `imem_addr=0`.
- With `IF_MISALIGN_TRAP_EN`, redirect to 0x102 → `misalignd=1` with `pcd=0x102`. Without the macro → `imem_addr=0x100`.
